// File: rtl/physmem_arb_pkg.sv
// Shared types for the I/D-cache physical-memory arbiter.
// Holds the FSM encoding, the latched-request bundle and the priority rule.
package physmem_arb_pkg;

    localparam int PM_ADDR_W = 16;
    localparam int PM_LINE_W = 128;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_SERVE_I,
        ARB_SERVE_D,
        ARB_RELEASE
    } arb_state_t;

    typedef struct packed {
        logic                 op_write;
        logic [PM_ADDR_W-1:0] addr;
        logic [PM_LINE_W-1:0] wdata;
        logic [1:0]           byte_enable;
    } arb_req_t;

    // D wins unless it just had a turn and I is waiting.
    function automatic logic d_wins(
        input logic d_req,
        input logic i_req,
        input logic last_was_d
    );
        return d_req && (!last_was_d || !i_req);
    endfunction

endpackage

// File: rtl/physmem_arbiter.sv
// Shares the physical-memory line port between I-cache and D-cache.
// One line transaction at a time; D has priority, I gets the turn after D.
module physmem_arbiter
    import physmem_arb_pkg::*;
#(
    parameter int ADDR_W = PM_ADDR_W,
    parameter int LINE_W = PM_LINE_W
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              icache_mem_read,
    input  logic [ADDR_W-1:0] icache_mem_addr,
    output logic [LINE_W-1:0] icache_mem_rdata,
    output logic              icache_mem_resp,

    input  logic              dcache_mem_read,
    input  logic              dcache_mem_write,
    input  logic [ADDR_W-1:0] dcache_mem_addr,
    input  logic [LINE_W-1:0] dcache_mem_wdata,
    input  logic [1:0]        dcache_byte_enable,
    output logic [LINE_W-1:0] dcache_mem_rdata,
    output logic              dcache_mem_resp,

    output logic              physicalmem_mem_read,
    output logic              physicalmem_mem_write,
    output logic [ADDR_W-1:0] physicalmem_mem_addr,
    output logic [LINE_W-1:0] physicalmem_mem_wdata,
    output logic [1:0]        physicalmem_byte_enable,
    input  logic              physicalmem_mem_response,
    input  logic [LINE_W-1:0] physicalmem_mem_rdata
);

    arb_state_t state_q;
    arb_state_t state_d;
    arb_req_t   req_q;
    arb_req_t   d_entry;
    arb_req_t   i_entry;
    logic       last_was_d_q;
    logic       mem_read_q;
    logic       mem_write_q;
    logic       d_req;
    logic       grant_i;
    logic       grant_d;
    logic       done;

    assign d_req = dcache_mem_read | dcache_mem_write;

    // Read+write together is a writeback.
    assign d_entry.op_write    = dcache_mem_write;
    assign d_entry.addr        = PM_ADDR_W'(dcache_mem_addr);
    assign d_entry.wdata       = PM_LINE_W'(dcache_mem_wdata);
    assign d_entry.byte_enable = dcache_byte_enable;

    assign i_entry.op_write    = 1'b0;
    assign i_entry.addr        = PM_ADDR_W'(icache_mem_addr);
    assign i_entry.wdata       = '0;
    assign i_entry.byte_enable = 2'b11;

    always_comb begin
        state_d         = state_q;
        grant_i         = 1'b0;
        grant_d         = 1'b0;
        done            = 1'b0;
        icache_mem_resp = 1'b0;
        dcache_mem_resp = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if (d_wins(d_req, icache_mem_read, last_was_d_q)) begin
                    grant_d = 1'b1;
                    state_d = ARB_SERVE_D;
                end else if (icache_mem_read) begin
                    grant_i = 1'b1;
                    state_d = ARB_SERVE_I;
                end
            end
            ARB_SERVE_I: begin
                if (physicalmem_mem_response) begin
                    icache_mem_resp = 1'b1;
                    done            = 1'b1;
                    state_d         = ARB_RELEASE;
                end
            end
            ARB_SERVE_D: begin
                if (physicalmem_mem_response) begin
                    dcache_mem_resp = 1'b1;
                    done            = 1'b1;
                    state_d         = ARB_RELEASE;
                end
            end
            ARB_RELEASE: state_d = ARB_IDLE;
            default:     state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ARB_IDLE;
            req_q        <= '0;
            last_was_d_q <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (grant_d) begin
                req_q       <= d_entry;
                mem_read_q  <= !dcache_mem_write;
                mem_write_q <= dcache_mem_write;
            end else if (grant_i) begin
                req_q       <= i_entry;
                mem_read_q  <= 1'b1;
                mem_write_q <= 1'b0;
            end else if (done) begin
                mem_read_q   <= 1'b0;
                mem_write_q  <= 1'b0;
                last_was_d_q <= (state_q == ARB_SERVE_D);
            end
        end
    end

    assign physicalmem_mem_read    = mem_read_q;
    assign physicalmem_mem_write   = mem_write_q;
    assign physicalmem_mem_addr    = req_q.addr[ADDR_W-1:0];
    assign physicalmem_mem_wdata   = req_q.wdata[LINE_W-1:0];
    assign physicalmem_byte_enable = req_q.byte_enable;

    assign icache_mem_rdata = physicalmem_mem_rdata;
    assign dcache_mem_rdata = physicalmem_mem_rdata;

endmodule

// File: tb/tb_physmem_arbiter.sv
// Bench for physmem_arbiter: directed scenarios, then random traffic,
// all checked every cycle against a transaction-level owner/cooldown model.
module tb_physmem_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         i_rd;
    logic [15:0]  i_addr;
    logic [127:0] i_rdata;
    logic         i_resp;
    logic         d_rd;
    logic         d_wr;
    logic [15:0]  d_addr;
    logic [127:0] d_wdata;
    logic [1:0]   d_be;
    logic [127:0] d_rdata;
    logic         d_resp;
    logic         pm_rd;
    logic         pm_wr;
    logic [15:0]  pm_addr;
    logic [127:0] pm_wdata;
    logic [1:0]   pm_be;
    logic         mem_resp;
    logic [127:0] mem_rdata;

    always #5 clk = ~clk;

    physmem_arbiter #(.ADDR_W(16), .LINE_W(128)) dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .icache_mem_read          (i_rd),
        .icache_mem_addr          (i_addr),
        .icache_mem_rdata         (i_rdata),
        .icache_mem_resp          (i_resp),
        .dcache_mem_read          (d_rd),
        .dcache_mem_write         (d_wr),
        .dcache_mem_addr          (d_addr),
        .dcache_mem_wdata         (d_wdata),
        .dcache_byte_enable       (d_be),
        .dcache_mem_rdata         (d_rdata),
        .dcache_mem_resp          (d_resp),
        .physicalmem_mem_read     (pm_rd),
        .physicalmem_mem_write    (pm_wr),
        .physicalmem_mem_addr     (pm_addr),
        .physicalmem_mem_wdata    (pm_wdata),
        .physicalmem_byte_enable  (pm_be),
        .physicalmem_mem_response (mem_resp),
        .physicalmem_mem_rdata    (mem_rdata)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: who owns the port (0 none, 1 I, 2 D), cooldown, fairness bit.
    int           owner;
    bit           quiet;
    bit           last_d;
    logic         m_wr;
    logic [15:0]  m_addr;
    logic [127:0] m_wdata;
    logic [1:0]   m_be;

    bit i_seen;
    bit d_seen;
    int lat;

    localparam logic [127:0] BEEF = 128'hDEAD_0000_0000_0000_0000_0000_0000_BEEF;
    localparam logic [127:0] WDAT = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;

    task automatic chk(input string name, input logic [127:0] got,
                       input logic [127:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic model_reset();
        owner   = 0;
        quiet   = 0;
        last_d  = 0;
        m_wr    = 0;
        m_addr  = '0;
        m_wdata = '0;
        m_be    = '0;
    endtask

    task automatic model_next();
        if (owner != 0 && mem_resp) begin
            last_d = (owner == 2);
            owner  = 0;
            quiet  = 1;
        end else if (owner == 0 && quiet) begin
            quiet = 0;
        end else if (owner == 0) begin
            if ((d_rd || d_wr) && (!last_d || !i_rd)) begin
                owner   = 2;
                m_wr    = d_wr;
                m_addr  = d_addr;
                m_wdata = d_wdata;
                m_be    = d_be;
            end else if (i_rd) begin
                owner   = 1;
                m_wr    = 0;
                m_addr  = i_addr;
                m_wdata = '0;
                m_be    = 2'b11;
            end
        end
    endtask

    // Compare this cycle, advance the model across the next edge.
    task automatic step();
        #1;
        if (!rst_n) model_reset();
        chk("mem_read", 128'(pm_rd), 128'(owner != 0 && !m_wr));
        chk("mem_write", 128'(pm_wr), 128'(owner != 0 && m_wr));
        chk("mem_addr", 128'(pm_addr), 128'(m_addr));
        chk("mem_wdata", pm_wdata, m_wdata);
        chk("mem_be", 128'(pm_be), 128'(m_be));
        chk("i_resp", 128'(i_resp), 128'(owner == 1 && mem_resp));
        chk("d_resp", 128'(d_resp), 128'(owner == 2 && mem_resp));
        chk("i_rdata", i_rdata, mem_rdata);
        chk("d_rdata", d_rdata, mem_rdata);
        if (i_resp) i_seen = 1;
        if (d_resp) d_seen = 1;
        if (rst_n) model_next();
        @(negedge clk);
        #1;
    endtask

    task automatic agents();
        if (i_rd && i_seen) begin
            i_rd   = 0;
            i_seen = 0;
        end else if (!i_rd && $urandom_range(0, 3) == 0) begin
            i_rd   = 1;
            i_addr = 16'($urandom);
        end else if (i_rd && $urandom_range(0, 7) == 0) begin
            i_addr = 16'($urandom);
        end
        if ((d_rd || d_wr) && d_seen) begin
            d_rd   = 0;
            d_wr   = 0;
            d_seen = 0;
        end else if (!(d_rd || d_wr) && $urandom_range(0, 2) == 0) begin
            case ($urandom_range(0, 2))
                0:       begin d_rd = 1; d_wr = 0; end
                1:       begin d_rd = 0; d_wr = 1; end
                default: begin d_rd = 1; d_wr = 1; end
            endcase
            d_addr  = 16'($urandom);
            d_wdata = {$urandom, $urandom, $urandom, $urandom};
            d_be    = 2'($urandom);
        end else if ((d_rd || d_wr) && $urandom_range(0, 5) == 0) begin
            d_addr  = 16'($urandom);
            d_wdata = {$urandom, $urandom, $urandom, $urandom};
            d_be    = 2'($urandom);
        end
        mem_rdata = {$urandom, $urandom, $urandom, $urandom};
        if (pm_rd || pm_wr) begin
            if (lat < 0) lat = $urandom_range(0, 5);
            if (lat == 0) begin
                mem_resp = 1;
                lat      = -1;
            end else begin
                mem_resp = 0;
                lat--;
            end
        end else begin
            lat      = -1;
            mem_resp = ($urandom_range(0, 5) == 0);
        end
    endtask

    initial begin
        rst_n     = 0;
        i_rd      = 0;
        i_addr    = '0;
        d_rd      = 0;
        d_wr      = 0;
        d_addr    = '0;
        d_wdata   = '0;
        d_be      = '0;
        mem_resp  = 0;
        mem_rdata = '0;
        i_seen    = 0;
        d_seen    = 0;
        lat       = -1;
        model_reset();
        @(negedge clk);
        #1;
        chk("rst_read", 128'(pm_rd), 128'(0));
        chk("rst_addr", 128'(pm_addr), 128'(0));
        step();
        rst_n = 1;
        step();

        // Lone I read, memory answers 5 cycles after the strobe rises
        i_rd   = 1;
        i_addr = 16'h0040;
        step();
        chk("lone_i_strobe", 128'(pm_rd), 128'(1));
        chk("lone_i_addr", 128'(pm_addr), 128'(16'h0040));
        repeat (5) step();
        mem_resp  = 1;
        mem_rdata = BEEF;
        #1;
        chk("lone_i_resp", 128'(i_resp), 128'(1));
        chk("lone_i_rdata", i_rdata, BEEF);
        chk("lone_i_dresp", 128'(d_resp), 128'(0));
        step();
        i_rd     = 0;
        mem_resp = 0;
        #1;
        chk("lone_i_pulse", 128'(i_resp), 128'(0));
        chk("lone_i_release", 128'(pm_rd), 128'(0));
        step();
        step();

        // D writeback
        d_wr    = 1;
        d_addr  = 16'h1230;
        d_wdata = WDAT;
        d_be    = 2'b01;
        step();
        chk("wb_write", 128'(pm_wr), 128'(1));
        chk("wb_read", 128'(pm_rd), 128'(0));
        chk("wb_addr", 128'(pm_addr), 128'(16'h1230));
        chk("wb_wdata", pm_wdata, WDAT);
        chk("wb_be", 128'(pm_be), 128'(2'b01));
        repeat (2) step();
        chk("wb_hold", 128'(pm_wr), 128'(1));
        mem_resp = 1;
        #1;
        chk("wb_dresp", 128'(d_resp), 128'(1));
        chk("wb_iresp", 128'(i_resp), 128'(0));
        step();
        d_wr     = 0;
        mem_resp = 0;
        #1;
        chk("wb_pulse", 128'(d_resp), 128'(0));
        chk("wb_release", 128'(pm_wr), 128'(0));
        step();
        step();

        // Simultaneous requests right after reset: D, I, D
        rst_n = 0;
        step();
        rst_n  = 1;
        i_rd   = 1;
        i_addr = 16'h0A00;
        d_rd   = 1;
        d_addr = 16'h0D00;
        step();
        chk("sim_first_d", 128'(pm_addr), 128'(16'h0D00));
        mem_resp = 1;
        step();
        mem_resp = 0;
        step();
        step();
        chk("sim_then_i", 128'(pm_addr), 128'(16'h0A00));
        chk("sim_then_i_rd", 128'(pm_rd), 128'(1));
        mem_resp = 1;
        step();
        i_rd     = 0;
        mem_resp = 0;
        step();
        step();
        chk("sim_then_d", 128'(pm_addr), 128'(16'h0D00));
        mem_resp = 1;
        step();
        d_rd     = 0;
        mem_resp = 0;
        step();
        step();

        // Address change mid-service
        d_rd   = 1;
        d_addr = 16'h0100;
        step();
        d_addr = 16'h0200;
        step();
        chk("addr_hold", 128'(pm_addr), 128'(16'h0100));
        mem_resp = 1;
        step();
        d_rd     = 0;
        mem_resp = 0;
        step();
        step();

        // Read and write together is a write
        d_rd   = 1;
        d_wr   = 1;
        d_addr = 16'h0ABC;
        step();
        chk("rw_write", 128'(pm_wr), 128'(1));
        chk("rw_read", 128'(pm_rd), 128'(0));
        mem_resp = 1;
        step();
        d_rd     = 0;
        d_wr     = 0;
        mem_resp = 0;
        step();
        step();

        // Reset during SERVE_I, then a late response
        i_rd   = 1;
        i_addr = 16'h0777;
        step();
        step();
        rst_n = 0;
        #1;
        chk("rst_mid_read", 128'(pm_rd), 128'(0));
        chk("rst_mid_addr", 128'(pm_addr), 128'(0));
        chk("rst_mid_be", 128'(pm_be), 128'(0));
        step();
        i_rd  = 0;
        rst_n = 1;
        step();
        mem_resp = 1;
        #1;
        chk("late_resp", 128'(i_resp), 128'(0));
        step();
        mem_resp = 0;
        step();

        i_seen = 0;
        d_seen = 0;
        lat    = -1;
        for (int n = 0; n < 3000; n++) begin
            agents();
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/physmem_arbiter.md
# physmem_arbiter

Two-requester arbiter sharing the single physical-memory line port between the instruction cache and the data cache of the pipelined core. It sits between the cache pair and the `physicalmem_*` port of `projtoplevel`, forwarding one 128-bit line transaction at a time. The data cache has priority, and the instruction cache is guaranteed the next grant after any data-cache transaction, so neither side starves.

## Interface
Parameters:
- `ADDR_W`, 16: physical line address width.
- `LINE_W`, 128: line data width.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `icache_mem_read`  in  1  I-cache line read request; level, held until `icache_mem_resp`.
- `icache_mem_addr`  in  ADDR_W  I-cache line address.
- `icache_mem_rdata`  out  LINE_W  read line to I-cache.
- `icache_mem_resp`  out  1  I-cache completion pulse.
- `dcache_mem_read`  in  1  D-cache line read request; level.
- `dcache_mem_write`  in  1  D-cache line writeback request; level.
- `dcache_mem_addr`  in  ADDR_W  D-cache line address.
- `dcache_mem_wdata`  in  LINE_W  writeback line.
- `dcache_byte_enable`  in  2  D-cache byte enable.
- `dcache_mem_rdata`  out  LINE_W  read line to D-cache.
- `dcache_mem_resp`  out  1  D-cache completion pulse.
- `physicalmem_mem_read`  out  1  memory read strobe; level.
- `physicalmem_mem_write`  out  1  memory write strobe; level.
- `physicalmem_mem_addr`  out  ADDR_W  memory address.
- `physicalmem_mem_wdata`  out  LINE_W  memory write data.
- `physicalmem_byte_enable`  out  2  memory byte enable.
- `physicalmem_mem_response`  in  1  memory completion pulse.
- `physicalmem_mem_rdata`  in  LINE_W  memory read data, valid with the response.

## Operation
- FSM states: IDLE, SERVE_I, SERVE_D, RELEASE.
- IDLE: if a D request is pending (`dcache_mem_read|dcache_mem_write`) and `last_was_d`=0 or no I request is pending, go to SERVE_D. Else, if `icache_mem_read` is pending, go to SERVE_I. Else stay in IDLE.
- On entering SERVE_x, latch the requester's addr, wdata, byte_enable and op. A D request with both read and write asserted is treated as a write. I transactions drive byte_enable 2'b11.
- SERVE_x: drive the latched op, addr, wdata and byte_enable to memory from registers. On `physicalmem_mem_response`:
  - forward it combinationally as `x_mem_resp`, with `physicalmem_mem_rdata` on `x_mem_rdata`;
  - set `last_was_d` to 1 for D, 0 for I;
  - go to RELEASE.
- RELEASE: all memory strobes low for one cycle, so the requester can drop its request. Then go to IDLE.
- `icache_mem_rdata` and `dcache_mem_rdata` are always wired to `physicalmem_mem_rdata`. Only the resp of the granted requester pulses.
- A requester dropping its request mid-service is illegal. The arbiter ignores it and completes the latched transaction.

## Timing
- Reset (async, `rst_n`=0):
  - state = IDLE, `last_was_d` = 0;
  - all physicalmem strobes 0, addr/wdata/byte_enable 0;
  - both resps 0.
- Reset deasserting mid-transaction abandons the transaction. No resp is issued afterwards.
- Request sampled in IDLE at edge N: memory strobe high from N+1.
- The response at cycle M is visible to the requester in the same cycle M (0-cycle forward). The strobe drops at edge M+1 (RELEASE). The next grant's strobe rises no earlier than M+3.
- Minimum turnaround between transactions is 2 cycles of strobe-low.
- Simultaneous I and D requests in IDLE: D wins if `last_was_d`=0, otherwise I wins.
- A response arriving in IDLE or RELEASE is ignored; no resp is forwarded.

## Structure
- Shared package `physmem_arb_pkg`:
  - `typedef enum logic [1:0] {ARB_IDLE, ARB_SERVE_I, ARB_SERVE_D, ARB_RELEASE} arb_state_t`;
  - `typedef struct packed` holding the latched request: op_write, addr, wdata, byte_enable.
- Single module, no sub-modules. One always_ff holds the state, the latch and `last_was_d`; one always_comb handles next-state and the resp steering.

## Test plan
- **Lone I read:** `icache_mem_read`=1, addr 16'h0040. Expect `physicalmem_mem_read`=1, addr 16'h0040, one cycle later. The memory responds with 128'hDEAD…BEEF after 5 cycles. Expect `icache_mem_resp` pulsing for exactly 1 cycle with that rdata, and `dcache_mem_resp` staying 0.
- **D writeback:** `dcache_mem_write`=1, addr 16'h1230, wdata 128'h0123…CDEF, be 2'b01. Expect `physicalmem_mem_write`=1 with those exact values until the response. Then expect strobe low and `dcache_mem_resp` to be a single pulse.
- **Simultaneous after reset:** I and D requests asserted at the same edge. Expect D served first. I must be served next even though D re-requests immediately, then D again.
- **Address change:** D changes addr from 16'h0100 to 16'h0200 mid-service. Expect `physicalmem_mem_addr` to stay at 16'h0100.
- **Reset mid-transaction:** `rst_n` pulsed low during SERVE_I. Expect all outputs 0 immediately and no `icache_mem_resp` afterwards. A late memory response must be ignored.
- **Read+write together:** D asserts both read and write. Expect only `physicalmem_mem_write` to be asserted.
